sdram_port_mux: RTL and testbench

- Sole client-side front end of the SDRAM byte controller.
- Arbitrates two sources onto one single-outstanding SDRAM command port:
  - HPS ioctl download writes, which carry the ROM, configuration, palette and background image.
  - Renderer image-byte reads, addressed relative to the image base decoded from the ROM header.
- Converts the controller's completion pulse into an ioctl_wait backpressure signal and an img_ready/img_data return.

---
 rtl/sdram_port_mux_if.sv | 63 ++++++
 rtl/sdram_port_mux.sv | 203 ++++++++++++++++++++
 tb/tb_sdram_port_mux.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_mux_if.sv
// -----------------------------------------------------------------------------
// sdram_port_mux_if
//   Bundles every bus signal of the SDRAM port multiplexer: the HPS ioctl
//   download port, the renderer image-read port, and the single-outstanding
//   SDRAM byte-controller command port.
//
//   Modports:
//     slave  - the multiplexer itself (sdram_port_mux)
//     master - the environment around it (hps_io, renderer and controller side)
//
//   Signals:
//     ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout  download write request
//     ioctl_wait                                     download backpressure
//     img_base/img_addr/img_read                     image read request
//     img_data/img_ready                             image read return
//     sdram_addr/sdram_din/sdram_rd/sdram_we         controller command
//     sdram_ready/sdram_dout                         controller completion
//     timeout_err                                    sticky watchdog flag
// -----------------------------------------------------------------------------
interface sdram_port_mux_if #(
    parameter int AW = 25
) ();
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;

    logic [AW-1:0] img_base;
    logic [AW-1:0] img_addr;
    logic          img_read;
    logic [7:0]    img_data;
    logic          img_ready;

    logic [AW-1:0] sdram_addr;
    logic [7:0]    sdram_din;
    logic          sdram_rd;
    logic          sdram_we;
    logic          sdram_ready;
    logic [7:0]    sdram_dout;

    logic          timeout_err;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait,
        input  img_base, img_addr, img_read,
        output img_data, img_ready,
        output sdram_addr, sdram_din, sdram_rd, sdram_we,
        input  sdram_ready, sdram_dout,
        output timeout_err
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait,
        output img_base, img_addr, img_read,
        input  img_data, img_ready,
        input  sdram_addr, sdram_din, sdram_rd, sdram_we,
        output sdram_ready, sdram_dout,
        input  timeout_err
    );
endinterface

// File: rtl/sdram_port_mux.sv
// -----------------------------------------------------------------------------
// sdram_port_mux
//   Client-side front end of the SDRAM byte controller. Arbitrates HPS ioctl
//   download writes and renderer image-byte reads onto one single-outstanding
//   command port. Writes always win over reads; an active download flushes and
//   blocks image reads. A watchdog abandons commands the controller never
//   completes and raises a sticky timeout_err.
//
//   Ports:
//     clk_sys  system clock, all logic on the rising edge
//     reset_n  asynchronous active-low reset
//     bus      sdram_port_mux_if.slave (ioctl, image and controller signals);
//              the interface AW must equal this module's AW
//
//   Parameters:
//     AW       address width of ioctl, image and SDRAM addresses
//     TIMEOUT  wait cycles before a command is abandoned (>= 2)
// -----------------------------------------------------------------------------
module sdram_port_mux #(
    parameter int AW      = 25,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    sdram_port_mux_if.slave      bus
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    state_t         state_reg, state_next;

    // single-entry capture buffers
    logic           wbuf_valid_reg, wbuf_valid_next;
    logic [AW-1:0]  wbuf_addr_reg,  wbuf_addr_next;
    logic [7:0]     wbuf_data_reg,  wbuf_data_next;
    logic           rbuf_valid_reg, rbuf_valid_next;
    logic [AW-1:0]  rbuf_addr_reg,  rbuf_addr_next;

    logic [WDW-1:0] wd_reg, wd_next;

    // registered outputs
    logic [AW-1:0]  sdram_addr_reg,  sdram_addr_next;
    logic [7:0]     sdram_din_reg,   sdram_din_next;
    logic           sdram_rd_reg,    sdram_rd_next;
    logic           sdram_we_reg,    sdram_we_next;
    logic [7:0]     img_data_reg,    img_data_next;
    logic           img_ready_reg,   img_ready_next;
    logic           ioctl_wait_reg,  ioctl_wait_next;
    logic           timeout_err_reg, timeout_err_next;

    // Image address is relative to the decoded base; the sum wraps at 2^AW.
    logic [AW-1:0]  img_req_addr;
    assign img_req_addr = bus.img_base + bus.img_addr;

    always_comb begin
        state_next       = state_reg;
        wbuf_valid_next  = wbuf_valid_reg;
        wbuf_addr_next   = wbuf_addr_reg;
        wbuf_data_next   = wbuf_data_reg;
        rbuf_valid_next  = rbuf_valid_reg;
        rbuf_addr_next   = rbuf_addr_reg;
        wd_next          = wd_reg;
        sdram_addr_next  = sdram_addr_reg;
        sdram_din_next   = sdram_din_reg;
        sdram_rd_next    = 1'b0;
        sdram_we_next    = 1'b0;
        img_data_next    = img_data_reg;
        img_ready_next   = 1'b0;
        timeout_err_next = timeout_err_reg;

        // Capture. A second write while the entry is valid simply overwrites
        // it; a newer read replaces an unissued one. Download flushes reads.
        if (bus.ioctl_wr) begin
            wbuf_valid_next = 1'b1;
            wbuf_addr_next  = bus.ioctl_addr;
            wbuf_data_next  = bus.ioctl_dout;
        end
        if (bus.ioctl_download) begin
            rbuf_valid_next = 1'b0;
        end else if (bus.img_read) begin
            rbuf_valid_next = 1'b1;
            rbuf_addr_next  = img_req_addr;
        end

        unique case (state_reg)
            ST_IDLE: begin
                wd_next = '0;
                // A request arriving while idle is issued at the same edge
                // that would have captured it, so the command pulse follows
                // the request by exactly one cycle. Stored entries are older
                // than new requests and go first; a new request arriving
                // together with a stored issue stays in the buffer.
                if (wbuf_valid_reg) begin
                    state_next      = ST_WR_WAIT;
                    sdram_addr_next = wbuf_addr_reg;
                    sdram_din_next  = wbuf_data_reg;
                    sdram_we_next   = 1'b1;
                    if (!bus.ioctl_wr) begin
                        wbuf_valid_next = 1'b0;
                    end
                end else if (bus.ioctl_wr) begin
                    state_next      = ST_WR_WAIT;
                    sdram_addr_next = bus.ioctl_addr;
                    sdram_din_next  = bus.ioctl_dout;
                    sdram_we_next   = 1'b1;
                    wbuf_valid_next = 1'b0;
                end else if (rbuf_valid_reg && !bus.ioctl_download) begin
                    state_next      = ST_RD_WAIT;
                    sdram_addr_next = rbuf_addr_reg;
                    sdram_rd_next   = 1'b1;
                    if (!bus.img_read) begin
                        rbuf_valid_next = 1'b0;
                    end
                end else if (bus.img_read && !bus.ioctl_download) begin
                    state_next      = ST_RD_WAIT;
                    sdram_addr_next = img_req_addr;
                    sdram_rd_next   = 1'b1;
                    rbuf_valid_next = 1'b0;
                end
            end

            ST_WR_WAIT, ST_RD_WAIT: begin
                // Completion wins over a coincident watchdog expiry.
                if (bus.sdram_ready) begin
                    state_next = ST_IDLE;
                    wd_next    = '0;
                    if (state_reg == ST_RD_WAIT) begin
                        img_data_next  = bus.sdram_dout;
                        img_ready_next = 1'b1;
                    end
                end else if (wd_reg == WD_LAST) begin
                    // The command has now spent TIMEOUT cycles waiting.
                    state_next       = ST_IDLE;
                    wd_next          = '0;
                    timeout_err_next = 1'b1;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                wd_next    = '0;
            end
        endcase

        // Backpressure covers both a queued write and one in flight.
        ioctl_wait_next = wbuf_valid_next || (state_next == ST_WR_WAIT);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            wbuf_valid_reg  <= 1'b0;
            wbuf_addr_reg   <= '0;
            wbuf_data_reg   <= '0;
            rbuf_valid_reg  <= 1'b0;
            rbuf_addr_reg   <= '0;
            wd_reg          <= '0;
            sdram_addr_reg  <= '0;
            sdram_din_reg   <= '0;
            sdram_rd_reg    <= 1'b0;
            sdram_we_reg    <= 1'b0;
            img_data_reg    <= '0;
            img_ready_reg   <= 1'b0;
            ioctl_wait_reg  <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wbuf_valid_reg  <= wbuf_valid_next;
            wbuf_addr_reg   <= wbuf_addr_next;
            wbuf_data_reg   <= wbuf_data_next;
            rbuf_valid_reg  <= rbuf_valid_next;
            rbuf_addr_reg   <= rbuf_addr_next;
            wd_reg          <= wd_next;
            sdram_addr_reg  <= sdram_addr_next;
            sdram_din_reg   <= sdram_din_next;
            sdram_rd_reg    <= sdram_rd_next;
            sdram_we_reg    <= sdram_we_next;
            img_data_reg    <= img_data_next;
            img_ready_reg   <= img_ready_next;
            ioctl_wait_reg  <= ioctl_wait_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign bus.sdram_addr  = sdram_addr_reg;
    assign bus.sdram_din   = sdram_din_reg;
    assign bus.sdram_rd    = sdram_rd_reg;
    assign bus.sdram_we    = sdram_we_reg;
    assign bus.img_data    = img_data_reg;
    assign bus.img_ready   = img_ready_reg;
    assign bus.ioctl_wait  = ioctl_wait_reg;
    assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_sdram_port_mux.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_mux
//   Self-checking bench for sdram_port_mux. A behavioural controller answers
//   each command after a programmable latency (or never, when silenced) and
//   returns addr[7:0]^8'h5A for reads. Expected commands and image bytes are
//   queued when stimulus is driven and compared as the DUT produces them.
//   All driving and sampling happens on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sdram_port_mux;

    localparam int AW = 25;

    typedef struct packed {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [7:0]    din;
    } cmd_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk_sys = ~clk_sys;

    sdram_port_mux_if #(.AW(AW)) bus ();

    sdram_port_mux #(.AW(AW), .TIMEOUT(16)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_img[$];

    int n_we  = 0;
    int n_rd  = 0;
    int n_rdy = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- controller model ----------------
    int            ctl_lat    = 3;
    bit            ctl_silent = 1'b0;
    bit            ctl_busy   = 1'b0;
    int            ctl_cnt    = 0;
    logic [AW-1:0] ctl_addr   = '0;

    always @(negedge clk_sys) begin
        bus.sdram_ready = 1'b0;
        if (ctl_busy) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
                bus.sdram_ready = 1'b1;
                bus.sdram_dout  = ctl_addr[7:0] ^ 8'h5A;
                ctl_busy        = 1'b0;
            end
        end
        if (reset_n && (bus.sdram_we || bus.sdram_rd) && !ctl_silent) begin
            ctl_busy = 1'b1;
            ctl_cnt  = ctl_lat;
            ctl_addr = bus.sdram_addr;
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    cmd_t       mon_c;
    logic [7:0] mon_d;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (bus.sdram_we && bus.sdram_rd)
                check_val("rd_we_exclusive", 1, 0);
            if (bus.sdram_we || bus.sdram_rd) begin
                if (bus.sdram_we) n_we++;
                if (bus.sdram_rd) n_rd++;
                if (exp_cmd.size() == 0) begin
                    check_val("unexpected_cmd", {7'd0, bus.sdram_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_c = exp_cmd.pop_front();
                    check_val("cmd_is_wr", bus.sdram_we, mon_c.is_wr);
                    check_val("cmd_addr", bus.sdram_addr, mon_c.addr);
                    if (mon_c.is_wr)
                        check_val("cmd_din", bus.sdram_din, mon_c.din);
                end
            end
            if (bus.img_ready) begin
                n_rdy++;
                if (exp_img.size() == 0) begin
                    check_val("unexpected_img_ready", {24'd0, bus.img_data}, 32'hFFFF_FFFF);
                end else begin
                    mon_d = exp_img.pop_front();
                    check_val("img_data", bus.img_data, mon_d);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic cmd_t mk_cmd(input logic w, input logic [AW-1:0] a, input logic [7:0] d);
        cmd_t c;
        c.is_wr = w;
        c.addr  = a;
        c.din   = d;
        return c;
    endfunction

    // One download byte from idle: ioctl_wait high for cycles 1..L+1 after
    // the ioctl_wr cycle, low at L+2.
    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d, input int lat);
        ctl_lat = lat;
        @(negedge clk_sys);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        exp_cmd.push_back(mk_cmd(1'b1, a, d));
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk_sys);
            if (k == 1) bus.ioctl_wr = 1'b0;
            check_val("ioctl_wait", bus.ioctl_wait, (k <= lat + 1));
        end
    endtask

    // One image read from idle: img_ready exactly 2+L cycles after request.
    task automatic do_read(input logic [AW-1:0] base, input logic [AW-1:0] a,
                           input int lat, input bit raise_dl);
        logic [AW-1:0] ea;
        ea      = base + a;
        ctl_lat = lat;
        @(negedge clk_sys);
        bus.img_base = base;
        bus.img_addr = a;
        bus.img_read = 1'b1;
        exp_cmd.push_back(mk_cmd(1'b0, ea, 8'h00));
        exp_img.push_back(ea[7:0] ^ 8'h5A);
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk_sys);
            if (k == 1) begin
                bus.img_read = 1'b0;
                if (raise_dl) bus.ioctl_download = 1'b1;
            end
            check_val("img_ready_timing", bus.img_ready, (k == lat + 2));
        end
    endtask

    int s_we, s_rd, s_rdy;

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.img_base       = '0;
        bus.img_addr       = '0;
        bus.img_read       = 1'b0;
        bus.sdram_ready    = 1'b0;
        bus.sdram_dout     = '0;

        // reset state
        repeat (3) @(negedge clk_sys);
        check_val("rst_ioctl_wait", bus.ioctl_wait, 0);
        check_val("rst_sdram_rd", bus.sdram_rd, 0);
        check_val("rst_sdram_we", bus.sdram_we, 0);
        check_val("rst_img_ready", bus.img_ready, 0);
        check_val("rst_img_data", bus.img_data, 0);
        check_val("rst_sdram_addr", bus.sdram_addr, 0);
        check_val("rst_sdram_din", bus.sdram_din, 0);
        check_val("rst_timeout_err", bus.timeout_err, 0);
        reset_n = 1'b1;

        // idle: no command pulses
        repeat (10) @(negedge clk_sys);
        check_val("idle_we_count", n_we, 0);
        check_val("idle_rd_count", n_rd, 0);
        $display("idle: no commands after reset");

        // download 4 bytes, L=3
        bus.ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = 8'hA0 + 8'(i);
            do_write(AW'(i), d, 3);
            $display("write addr=%0h data=%0h", i, d);
        end
        bus.ioctl_download = 1'b0;
        check_val("dl_we_count", n_we, 4);

        // image read, L=4, latency 6
        do_read(25'h0100000, 25'h0000123, 4, 1'b0);
        $display("read base=100000 addr=123 -> sdram 100123");

        // address wrap
        do_read(25'h1FFFFFF, 25'h0000002, 2, 1'b0);
        $display("read wrap base=1ffffff addr=2 -> sdram 1");

        // simultaneous write+read while downloading: read dropped
        ctl_lat = 3;
        bus.ioctl_download = 1'b1;
        s_we = n_we; s_rd = n_rd; s_rdy = n_rdy;
        @(negedge clk_sys);
        bus.ioctl_wr   = 1'b1; bus.ioctl_addr = 25'h0000010; bus.ioctl_dout = 8'h3C;
        bus.img_read   = 1'b1; bus.img_base   = 25'h0000200; bus.img_addr   = 25'h0000001;
        exp_cmd.push_back(mk_cmd(1'b1, 25'h0000010, 8'h3C));
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0; bus.img_read = 1'b0;
        repeat (12) @(negedge clk_sys);
        check_val("prio_dl_we", n_we - s_we, 1);
        check_val("prio_dl_rd", n_rd - s_rd, 0);
        check_val("prio_dl_rdy", n_rdy - s_rdy, 0);
        bus.ioctl_download = 1'b0;
        $display("simultaneous wr+rd during download: write only");

        // simultaneous write+read, no download: both, write first
        s_we = n_we; s_rd = n_rd; s_rdy = n_rdy;
        @(negedge clk_sys);
        bus.ioctl_wr   = 1'b1; bus.ioctl_addr = 25'h0000020; bus.ioctl_dout = 8'h81;
        bus.img_read   = 1'b1; bus.img_base   = 25'h0000300; bus.img_addr   = 25'h0000004;
        exp_cmd.push_back(mk_cmd(1'b1, 25'h0000020, 8'h81));
        exp_cmd.push_back(mk_cmd(1'b0, 25'h0000304, 8'h00));
        exp_img.push_back(8'h04 ^ 8'h5A);
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0; bus.img_read = 1'b0;
        repeat (16) @(negedge clk_sys);
        check_val("prio_we", n_we - s_we, 1);
        check_val("prio_rd", n_rd - s_rd, 1);
        check_val("prio_rdy", n_rdy - s_rdy, 1);
        $display("simultaneous wr+rd: write then read");

        // read in flight when download rises still completes
        do_read(25'h0000400, 25'h0000033, 4, 1'b1);
        bus.ioctl_download = 1'b0;
        $display("read completes across download rise");

        // read timeout: controller silent, TIMEOUT=16
        ctl_silent = 1'b1;
        @(negedge clk_sys);
        bus.img_base = 25'h0000040; bus.img_addr = 25'h0000005; bus.img_read = 1'b1;
        exp_cmd.push_back(mk_cmd(1'b0, 25'h0000045, 8'h00));
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk_sys);
            if (k == 1) bus.img_read = 1'b0;
            if (k == 16) check_val("to_err_before", bus.timeout_err, 0);
            if (k == 17) check_val("to_err_set", bus.timeout_err, 1);
            check_val("to_no_img_ready", bus.img_ready, 0);
        end
        $display("read timeout: timeout_err=%0b", bus.timeout_err);

        // write timeout releases ioctl_wait
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0001234; bus.ioctl_dout = 8'h77;
        exp_cmd.push_back(mk_cmd(1'b1, 25'h0001234, 8'h77));
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk_sys);
            if (k == 1) bus.ioctl_wr = 1'b0;
            if (k == 16) check_val("wto_wait_held", bus.ioctl_wait, 1);
            if (k == 17) check_val("wto_wait_released", bus.ioctl_wait, 0);
        end
        $display("write timeout: ioctl_wait released");
        ctl_silent = 1'b0;

        // following write completes normally
        do_write(25'h0000055, 8'hC3, 2);
        check_val("err_sticky", bus.timeout_err, 1);
        $display("write after timeout addr=55 data=c3");

        repeat (5) @(negedge clk_sys);
        check_val("sb_cmd_empty", exp_cmd.size(), 0);
        check_val("sb_img_empty", exp_img.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
